step_counter: RTL and testbench

Front-end pedometer stage: takes the raw asynchronous step-sensor pulse and synchronizes it, debounces it, and rate-limits it. It accumulates accepted steps into a 16-bit running total, `step_count`, which feeds the steps-per-minute calculator directly downstream. It also emits a one-cycle `step_pulse` per accepted step for display/LED logic.

---
 rtl/step_counter.sv | 153 +++++++++++++++
 tb/tb_step_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// step_counter: synchronizes, debounces and rate-limits a raw step-sensor
// input, then accumulates accepted steps into a saturating 16-bit total.
module step_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MIN_STEP_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic        step_raw,
    output logic        step_pulse,
    output logic [15:0] step_count,
    output logic        saturated
);

    localparam int unsigned DCNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned LCNT_W  = (MIN_STEP_CYCLES > 1) ? $clog2(MIN_STEP_CYCLES) : 1;
    localparam int unsigned COUNT_W = 16;

    localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCNT_W-1:0]  LCNT_LAST = LCNT_W'(MIN_STEP_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        LOCKOUT  = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    logic              sync_meta;
    logic              sync;
    logic              db;
    logic              db_d;
    logic [DCNT_W-1:0] dcnt;
    logic              rise;

    state_t            state;
    state_t            state_nxt;
    logic [LCNT_W-1:0] lcnt;
    logic [LCNT_W-1:0] lcnt_nxt;
    logic              accept;

    // Two-flop synchronizer for the asynchronous sensor input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= step_raw;
            sync      <= sync_meta;
        end
    end

    // Debouncer: db follows sync only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db   <= 1'b0;
            dcnt <= '0;
        end else if (sync == db) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            db   <= sync;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DCNT_W'(1);
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_d <= 1'b0;
        end else begin
            db_d <= db;
        end
    end

    assign rise = db & ~db_d;

    // Rate-limiter state and lockout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARMED;
            lcnt  <= '0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    // Next-state logic: accept from ARMED, hold off in LOCKOUT, require a low level before re-arming.
    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        accept    = 1'b0;
        case (state)
            ARMED: begin
                if (rise && enable) begin
                    accept    = 1'b1;
                    state_nxt = LOCKOUT;
                    lcnt_nxt  = '0;
                end
            end
            LOCKOUT: begin
                if (lcnt == LCNT_LAST) begin
                    lcnt_nxt  = '0;
                    state_nxt = db ? WAIT_LOW : ARMED;
                end else begin
                    lcnt_nxt = lcnt + LCNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (!db) begin
                    state_nxt = ARMED;
                end
            end
            default: begin
                state_nxt = ARMED;
                lcnt_nxt  = '0;
            end
        endcase
        // Clear wins over a coincident accept; the step is dropped.
        if (clear) begin
            state_nxt = ARMED;
            lcnt_nxt  = '0;
            accept    = 1'b0;
        end
    end

    // Registered outputs: one-cycle pulse and saturating count per accepted step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_pulse <= 1'b0;
            step_count <= '0;
            saturated  <= 1'b0;
        end else if (clear) begin
            step_pulse <= 1'b0;
            step_count <= '0;
            saturated  <= 1'b0;
        end else begin
            step_pulse <= accept;
            if (accept) begin
                if (step_count != COUNT_MAX) begin
                    step_count <= step_count + COUNT_W'(1);
                end else begin
                    saturated <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: randomized and directed checks of step_counter against a
// behavioural model built from stable-sample windows and accept spacing.
module tb_step_counter;

    localparam int unsigned D = 4;
    localparam int unsigned M = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic        step_raw;
    logic        step_pulse;
    logic [15:0] step_count;
    logic        saturated;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_hist[$];
    bit          m_db;
    bit          m_rose;
    bit          m_have_last;
    bit          m_pulse;
    bit          m_sat;
    int          m_t;
    int          m_last;
    logic [15:0] m_count;

    // Observed pulse statistics per scenario
    int pulse_cnt;
    int last_obs;
    int min_gap;
    int obs_t = 0;

    step_counter #(
        .DEBOUNCE_CYCLES(D),
        .MIN_STEP_CYCLES(M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear     (clear),
        .step_raw  (step_raw),
        .step_pulse(step_pulse),
        .step_count(step_count),
        .saturated (saturated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < int'(D) + 2; i++) m_hist.push_back(1'b0);
        m_db        = 1'b0;
        m_rose      = 1'b0;
        m_have_last = 1'b0;
        m_pulse     = 1'b0;
        m_sat       = 1'b0;
        m_count     = 16'h0000;
        m_t         = 0;
        m_last      = 0;
    endfunction

    // One clock edge of the model: the level changes once the last D synchronized
    // samples (raw delayed by two edges) all disagree with it; a step is accepted
    // the edge after a rising level change if enabled and at least M+1 edges have
    // passed since the previous accept (clear/reset forget the previous accept).
    function automatic void model_edge(input bit raw, input bit en, input bit clr);
        bit acc;
        bit flip;
        m_t++;
        acc = m_rose && en && (!m_have_last || (m_t - m_last) >= int'(M) + 1);
        if (clr) begin
            m_count     = 16'h0000;
            m_sat       = 1'b0;
            m_pulse     = 1'b0;
            m_have_last = 1'b0;
        end else begin
            m_pulse = acc;
            if (acc) begin
                m_have_last = 1'b1;
                m_last      = m_t;
                if (m_count == 16'hFFFF) m_sat = 1'b1;
                else m_count = m_count + 16'd1;
            end
        end
        m_hist.push_front(raw);
        void'(m_hist.pop_back());
        flip = 1'b1;
        for (int i = 2; i <= int'(D) + 1; i++) begin
            if (m_hist[i] == m_db) flip = 1'b0;
        end
        m_rose = flip && !m_db;
        if (flip) m_db = !m_db;
    endfunction

    // Drive inputs at the falling edge, advance the model on the rising edge, compare on the next falling edge.
    task automatic cycle(input bit raw, input bit en, input bit clr);
        step_raw = raw;
        enable   = en;
        clear    = clr;
        @(posedge clk);
        model_edge(raw, en, clr);
        @(negedge clk);
        obs_t++;
        if (step_pulse === 1'b1) begin
            pulse_cnt++;
            if (last_obs >= 0 && (obs_t - last_obs) < min_gap) min_gap = obs_t - last_obs;
            last_obs = obs_t;
        end
        check("pulse", 32'(step_pulse), 32'(m_pulse));
        check("count", 32'(step_count), 32'(m_count));
        check("sat", 32'(saturated), 32'(m_sat));
    endtask

    task automatic scen_start();
        pulse_cnt = 0;
        last_obs  = -1;
        min_gap   = 1_000_000;
    endtask

    task automatic steps(input int high, input int low, input bit en, input int n);
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < high; i++) cycle(1'b1, en, 1'b0);
            for (int i = 0; i < low; i++) cycle(1'b0, en, 1'b0);
        end
    endtask

    initial begin
        int first_idx;
        int run;
        bit lvl;

        rst      = 1'b0;
        enable   = 1'b1;
        clear    = 1'b0;
        step_raw = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pulse", 32'(step_pulse), 32'd0);
        check("rst_count", 32'(step_count), 32'd0);
        check("rst_sat", 32'(saturated), 32'd0);
        rst = 1'b1;

        // Clean step: high held 50 cycles, pulse 7 edges after the drive edge.
        scen_start();
        first_idx = 0;
        for (int i = 1; i <= 50; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (step_pulse === 1'b1 && first_idx == 0) first_idx = i;
        end
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0);
        check("clean_latency", 32'(first_idx), 32'd7);
        check("clean_pulses", 32'(pulse_cnt), 32'd1);
        check("clean_count", 32'(step_count), 32'd1);

        // Glitches shorter than the debounce window.
        scen_start();
        steps(3, 3, 1'b1, 10);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0);
        check("glitch_pulses", 32'(pulse_cnt), 32'd0);
        check("glitch_count", 32'(step_count), 32'd1);

        // Steps every 15 cycles: lockout drops every other one.
        scen_start();
        steps(10, 5, 1'b1, 8);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0);
        check("lock_pulses", 32'(pulse_cnt), 32'd4);
        check("lock_gap_ok", 32'(min_gap >= int'(M) + 1), 32'd1);
        check("lock_count", 32'(step_count), 32'd5);

        // Steps every 40 cycles: all accepted.
        scen_start();
        steps(10, 30, 1'b1, 4);
        check("slow_pulses", 32'(pulse_cnt), 32'd4);
        check("slow_count", 32'(step_count), 32'd9);

        // Randomized activity with occasional enable drops and clears.
        scen_start();
        run = 0;
        lvl = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (run == 0) begin
                lvl = ~lvl;
                run = int'($urandom_range(1, 30));
            end
            run--;
            cycle(lvl, ($urandom_range(0, 7) != 0), ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0);

        // Saturation: preload the count to 0xFFFE, then three steps.
        force dut.step_count = 16'hFFFE;
        #1;
        release dut.step_count;
        #1;
        m_count = 16'hFFFE;
        m_sat   = 1'b0;
        scen_start();
        cycle(1'b0, 1'b1, 1'b0);
        check("preload", 32'(step_count), 32'hFFFE);
        steps(10, 30, 1'b1, 1);
        check("sat1_count", 32'(step_count), 32'hFFFF);
        check("sat1_flag", 32'(saturated), 32'd0);
        steps(10, 30, 1'b1, 1);
        check("sat2_count", 32'(step_count), 32'hFFFF);
        check("sat2_flag", 32'(saturated), 32'd1);
        steps(10, 30, 1'b1, 1);
        check("sat3_count", 32'(step_count), 32'hFFFF);
        check("sat_pulses", 32'(pulse_cnt), 32'd3);
        cycle(1'b0, 1'b1, 1'b1);
        check("clr_count", 32'(step_count), 32'd0);
        check("clr_sat", 32'(saturated), 32'd0);

        // Enable low: steps ignored, count held.
        scen_start();
        steps(10, 30, 1'b0, 5);
        check("dis_pulses", 32'(pulse_cnt), 32'd0);
        check("dis_count", 32'(step_count), 32'd0);

        // Clear coinciding with the accept edge.
        steps(10, 30, 1'b1, 1);
        check("pre_coll_count", 32'(step_count), 32'd1);
        scen_start();
        for (int i = 1; i <= 10; i++) cycle(1'b1, 1'b1, (i == 7));
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0);
        check("coll_pulses", 32'(pulse_cnt), 32'd0);
        check("coll_count", 32'(step_count), 32'd0);

        // Asynchronous reset ten cycles into lockout.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0);
        check("pre_arst_count", 32'(step_count), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pulse", 32'(step_pulse), 32'd0);
        check("arst_count", 32'(step_count), 32'd0);
        check("arst_sat", 32'(saturated), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        scen_start();
        first_idx = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (step_pulse === 1'b1 && first_idx == 0) first_idx = i;
        end
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0);
        check("post_arst_latency", 32'(first_idx), 32'd7);
        check("post_arst_count", 32'(step_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
